// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command issuer:
//   - opcode constants, encoded as {s[1:0], s1[1:0]}
//   - issuer FSM state type
//   - is_legal_op() / is_arith_op() helpers
// ---------------------------------------------------------------------------
package alu_pkg;

  // s1 selects the output mux (00 arith, 01 logic, 10 shift).
  // s selects the operation within that group.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_INC = 4'b1000;
  localparam logic [3:0] OP_DEC = 4'b1100;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_NOT = 4'b1101;
  localparam logic [3:0] OP_ASR = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC,
      OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_ASR:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Arithmetic ops are the only ones whose carry-out is meaningful.
  function automatic logic is_arith_op(input logic [3:0] op);
    return is_legal_op(op) && (op[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Combinational opcode decoder for the ALU command issuer.
// Ports:
//   i_op           in  4  opcode {s[1:0], s1[1:0]}
//   o_legal        out 1  opcode is one of the nine supported operations
//   o_s            out 2  arithmetic/logic select for the ALU
//   o_s1           out 2  ALU output-mux select
//   o_carry_valid  out 1  ALU carry-out is meaningful for this opcode
// ---------------------------------------------------------------------------
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0] i_op,
  output logic       o_legal,
  output logic [1:0] o_s,
  output logic [1:0] o_s1,
  output logic       o_carry_valid
);

  assign o_legal       = is_legal_op(i_op);
  assign o_s           = i_op[3:2];
  assign o_s1          = i_op[1:0];
  assign o_carry_valid = is_arith_op(i_op);

endmodule

// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
// Initiator for a combinational N-bit ALU. Takes one command {op,a,b}, drives
// the ALU select/operand lines from registers, holds them for SETTLE_CYCLES
// cycles, captures result/carry and presents a response. One command in
// flight at a time.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high. The producer holds valid and its
// payload stable until that edge; ready may be asserted independently of
// valid.
//
// Parameters:
//   N              operand/result width
//   SETTLE_CYCLES  cycles the ALU inputs are held before capture (>= 1)
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_ready only in IDLE
//   cmd_op/cmd_a/cmd_b         command payload
//   alu_a/alu_b/alu_s/alu_s1   registered ALU operands and selects
//   alu_cin                    carry-in, alu_s[1]^alu_s[0]
//   alu_ins                    shift fill bit, alu_a[N-1]
//   alu_result/alu_carry       ALU outputs
//   rsp_valid/rsp_ready        response handshake
//   rsp_result/rsp_carry/rsp_err  response payload
// Optional feature (macro ALU_STATUS_FLAGS_EN):
//   rsp_zero/rsp_neg/rsp_ovf   status flags captured with the result
// ---------------------------------------------------------------------------
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int N             = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [1:0]   alu_s,
  output logic [1:0]   alu_s1,
  output logic         alu_cin,
  output logic         alu_ins,
  input  logic [N-1:0] alu_result,
  input  logic         alu_carry,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_err
`ifdef ALU_STATUS_FLAGS_EN
  ,
  output logic         rsp_zero,
  output logic         rsp_neg,
  output logic         rsp_ovf
`endif
);

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("alu_cmd_issuer: SETTLE_CYCLES must be at least 1");
    end
  endgenerate

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

  // Decoder outputs
  logic       w_legal;
  logic [1:0] w_s;
  logic [1:0] w_s1;
  logic       w_carry_valid;

  alu_op_decode u_decode (
    .i_op          (cmd_op),
    .o_legal       (w_legal),
    .o_s           (w_s),
    .o_s1          (w_s1),
    .o_carry_valid (w_carry_valid)
  );

  state_e         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_cmd_ready;
  logic [N-1:0]   r_alu_a;
  logic [N-1:0]   r_alu_b;
  logic [1:0]     r_alu_s;
  logic [1:0]     r_alu_s1;
  logic           r_carry_valid;
  logic           r_rsp_valid;
  logic [N-1:0]   r_rsp_result;
  logic           r_rsp_carry;
  logic           r_rsp_err;

  wire w_accept = cmd_valid && r_cmd_ready;

`ifdef ALU_STATUS_FLAGS_EN
  logic         r_rsp_zero;
  logic         r_rsp_neg;
  logic         r_rsp_ovf;
  logic [N-1:0] w_b_eff;
  logic         w_ovf;

  // Second adder operand as the ALU sees it, so overflow can be derived
  // from sign bits alone: a + b_eff + cin.
  always_comb begin
    w_b_eff = r_alu_b;
    case (r_alu_s)
      2'b00:   w_b_eff = r_alu_b;
      2'b01:   w_b_eff = ~r_alu_b;
      2'b10:   w_b_eff = '0;
      default: w_b_eff = '1;
    endcase
  end

  // Signed overflow: operands share a sign and the result sign differs.
  assign w_ovf = r_carry_valid &&
                 (r_alu_a[N-1] == w_b_eff[N-1]) &&
                 (alu_result[N-1] != r_alu_a[N-1]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_cmd_ready   <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_s       <= '0;
      r_alu_s1      <= '0;
      r_carry_valid <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_carry   <= 1'b0;
      r_rsp_err     <= 1'b0;
`ifdef ALU_STATUS_FLAGS_EN
      r_rsp_zero    <= 1'b0;
      r_rsp_neg     <= 1'b0;
      r_rsp_ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          // cmd_ready is raised on the first edge after reset release and
          // stays up until a command is accepted.
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            if (w_legal) begin
              r_alu_a       <= cmd_a;
              r_alu_b       <= cmd_b;
              r_alu_s       <= w_s;
              r_alu_s1      <= w_s1;
              r_carry_valid <= w_carry_valid;
              r_cnt         <= CNT_INIT;
              r_state       <= ST_DRIVE;
            end else begin
              // Illegal opcode: leave the ALU lines alone, answer at once.
              r_rsp_valid  <= 1'b1;
              r_rsp_result <= '0;
              r_rsp_carry  <= 1'b0;
              r_rsp_err    <= 1'b1;
`ifdef ALU_STATUS_FLAGS_EN
              r_rsp_zero   <= 1'b0;
              r_rsp_neg    <= 1'b0;
              r_rsp_ovf    <= 1'b0;
`endif
              r_state      <= ST_RESP;
            end
          end
        end

        ST_DRIVE: begin
          if (r_cnt == '0) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= alu_result;
            r_rsp_carry  <= r_carry_valid && alu_carry;
            r_rsp_err    <= 1'b0;
`ifdef ALU_STATUS_FLAGS_EN
            r_rsp_zero   <= (alu_result == '0);
            r_rsp_neg    <= alu_result[N-1];
            r_rsp_ovf    <= w_ovf;
`endif
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        ST_RESP: begin
          // Payload holds until the consumer takes it; cmd_ready returns
          // on the following cycle, never in the same one.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_s      = r_alu_s;
  assign alu_s1     = r_alu_s1;
  assign alu_cin    = r_alu_s[1] ^ r_alu_s[0];
  assign alu_ins    = r_alu_a[N-1];
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_err    = r_rsp_err;
`ifdef ALU_STATUS_FLAGS_EN
  assign rsp_zero   = r_rsp_zero;
  assign rsp_neg    = r_rsp_neg;
  assign rsp_ovf    = r_rsp_ovf;
`endif

endmodule
